decode_ctrl_pipe: RTL and testbench
===================================

# decode_ctrl_pipe

Registered, handshaked successor to the combinational RV32I opcode decoder. It sits between fetch and execute, taking a 7-bit opcode per accepted instruction and presenting the registered control bundle one cycle later. It adds valid/ready flow control, flush, and an outstanding-memory-operation counter. The counter makes FENCE/FENCE.I wait until all issued loads and stores have completed.

## Interface
- `CNT_W`, 4: width of the outstanding-memory counter; maximum outstanding = 2^CNT_W−1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  opcode valid from fetch.
- `in_ready`  out  1  block can accept an opcode this cycle.
- `opcode`  in  7  instruction[6:0].
- `flush`  in  1  synchronous kill of the held output and any fence wait.
- `out_valid`  out  1  control bundle valid.
- `out_ready`  in  1  execute consumes the bundle.
- `mem_to_reg, reg_write, mem_write, mem_read, branch, alu_src, jump, jalr, lui, auipc, fence`  out  1 each  registered control bundle.
- `illegal`  out  1  registered illegal-opcode flag (see Configuration).
- `mem_req`  in  1  one load/store issued to memory this cycle.
- `mem_ack`  in  1  one load/store completed this cycle.
- `outstanding`  out  CNT_W  current outstanding count.
- `fence_busy`  out  1  high while in DRAIN.
- `cnt_err`  out  1  sticky; set on `mem_ack` at count 0 or on `mem_req` at max.

## Operation
- Decode table (all unlisted bits 0):
  - load 0000011: mem_to_reg, reg_write, mem_read, alu_src.
  - store 0100011: mem_write, alu_src.
  - branch 1100011: branch.
  - OP-IMM 0010011: reg_write, alu_src.
  - OP 0110011: reg_write.
  - jal 1101111: jump, reg_write.
  - jalr 1100111: jump, jalr, reg_write, alu_src.
  - lui 0110111: reg_write, lui.
  - auipc 0010111: reg_write, auipc, alu_src.
  - fence 0001111: fence only; no reg_write.
- Handshake:
  - Accept when `in_valid && in_ready`.
  - `in_ready = (!out_valid || out_ready) && state==RUN && !flush`.
  - Output bundle holds stable while `out_valid && !out_ready`.
- Counter:
  - `mem_req` increments; `mem_ack` decrements; both together leave the count unchanged.
  - Increment at max saturates and sets `cnt_err`.
  - Decrement at 0 holds 0 and sets `cnt_err`.
- States:
  - RUN: normal acceptance.
  - DRAIN: entered when a fence is accepted and the next count is nonzero. `out_valid` stays low and `in_ready` stays low.
  - DRAIN→RUN when the next count == 0; `out_valid` rises on that edge with the fence bundle.
  - A fence accepted with next count 0 stays in RUN and behaves as a normal opcode.
- Flush:
  - Clears `out_valid` and returns to RUN on the next edge.
  - Does not clear the counter or `cnt_err`.
  - Flush wins over a same-cycle accept.
- Reset: `out_valid`, all bundle bits, `illegal`, `outstanding`, `cnt_err`, `fence_busy` all 0; state RUN; `in_ready` 1 after reset deasserts.

## Timing
- Latency is 1 cycle: accept at edge N, `out_valid` high after edge N.
- Full throughput is 1 opcode/cycle while `out_ready` is held high.
- `outstanding` is registered and reflects `mem_req`/`mem_ack` from the previous cycle.
- Fence latency is 1 cycle plus the cycles until the count reaches 0.
- `fence_busy` is registered, equals (state==DRAIN), and rises the edge after fence acceptance.
- `rst` asserted mid-DRAIN clears everything immediately, without waiting for a clock edge.

## Configuration
- `DECODE_ILLEGAL_EN` defined:
  - Any opcode outside the table, or with `opcode[1:0] != 2'b11`, registers `illegal=1` with all other bundle bits 0.
  - The opcode is still handed over normally and never enters DRAIN.
- `DECODE_ILLEGAL_EN` undefined:
  - `illegal` is tied to 0.
  - Unlisted opcodes produce an all-zero bundle.

## Test plan
- Back-to-back load, store, OP, jal, lui, auipc with `out_ready=1` -> one bundle per cycle, 1-cycle latency; load shows mem_to_reg=1, reg_write=1, mem_read=1, alu_src=1, all others 0.
- Backpressure: accept OP-IMM, hold `out_ready=0` for 3 cycles -> bundle stable, `in_ready=0`; `out_ready=1` -> new opcode accepted the same cycle.
- Fence drain: 3 `mem_req` pulses, accept fence -> `fence_busy=1`; 3 `mem_ack` pulses -> `out_valid` with fence=1 on the edge the count hits 0; simultaneous req+ack holds the count.
- Counter errors: `mem_ack` at 0 -> count stays 0, `cnt_err=1`; with CNT_W=2, 4 `mem_req` pulses -> count saturates at 3, `cnt_err=1`.
- Flush in DRAIN with count 2 -> state RUN, `out_valid=0`, count still 2; async `rst` mid-DRAIN -> all outputs 0 immediately.
- Opcode 1111111 -> with `DECODE_ILLEGAL_EN`, `illegal=1` and all other bundle bits 0; without it, the whole bundle is 0.

Source files
------------

// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : decode_ctrl_pipe
//  Purpose  : Registered, valid/ready-handshaked RV32I opcode decoder with
//             flush and an outstanding-memory-operation counter that holds
//             FENCE/FENCE.I until all issued loads/stores have completed.
//  Options  : DECODE_ILLEGAL_EN - flag opcodes outside the decode table.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_ctrl_pipe #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             mem_write,
    output logic             mem_read,
    output logic             branch,
    output logic             alu_src,
    output logic             jump,
    output logic             jalr,
    output logic             lui,
    output logic             auipc,
    output logic             fence,
    output logic             illegal,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] outstanding,
    output logic             fence_busy,
    output logic             cnt_err
);

    // Bundle bit layout: {illegal, mem_to_reg, reg_write, mem_write, mem_read,
    //                     branch, alu_src, jump, jalr, lui, auipc, fence}
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [11:0]      bundle_q, bundle_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_err_q, cnt_err_d;
    logic [11:0]      w_dec;
    logic             w_in_ready;
    logic             w_accept;

    assign w_in_ready = (!out_valid_q || out_ready) && (state_q == S_RUN) && !flush;
    assign w_accept   = in_valid && w_in_ready;

    // Opcode decode into the control bundle.
    always_comb begin
        w_dec = 12'h000;
        case (opcode)
            7'b0000011: w_dec = 12'h6A0; // load
            7'b0100011: w_dec = 12'h120; // store
            7'b1100011: w_dec = 12'h040; // branch
            7'b0010011: w_dec = 12'h220; // OP-IMM
            7'b0110011: w_dec = 12'h200; // OP
            7'b1101111: w_dec = 12'h210; // jal
            7'b1100111: w_dec = 12'h238; // jalr
            7'b0110111: w_dec = 12'h204; // lui
            7'b0010111: w_dec = 12'h222; // auipc
            7'b0001111: w_dec = 12'h001; // fence
            default: begin
`ifdef DECODE_ILLEGAL_EN
                w_dec = 12'h800;         // only the illegal flag
`else
                w_dec = 12'h000;
`endif
            end
        endcase
    end

    // Outstanding-counter next state: saturate at both ends and flag misuse.
    always_comb begin
        cnt_d     = cnt_q;
        cnt_err_d = cnt_err_q;
        if (mem_req && !mem_ack) begin
            if (cnt_q == C_CNT_MAX) cnt_err_d = 1'b1;
            else                    cnt_d     = cnt_q + C_CNT_ONE;
        end else if (mem_ack && !mem_req) begin
            if (cnt_q == '0) cnt_err_d = 1'b1;
            else             cnt_d     = cnt_q - C_CNT_ONE;
        end
    end

    // RUN/DRAIN next state plus output-register load/hold/clear decisions.
    always_comb begin
        state_d     = state_q;
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_RUN: begin
                if (flush) begin
                    out_valid_d = 1'b0;
                end else if (w_accept) begin
                    bundle_d = w_dec;
                    // A fence with memory still in flight parks the bundle
                    // in the register but withholds out_valid until drained.
                    if (w_dec[0] && (cnt_d != '0)) begin
                        state_d     = S_DRAIN;
                        out_valid_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    state_d     = S_RUN;
                    out_valid_d = 1'b0;
                end else if (cnt_d == '0) begin
                    state_d     = S_RUN;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_RUN;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State, output bundle and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            bundle_q    <= 12'h000;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            cnt_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
            cnt_err_q   <= cnt_err_d;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = out_valid_q;
    assign outstanding = cnt_q;
    assign cnt_err     = cnt_err_q;
    assign fence_busy  = (state_q == S_DRAIN);
    assign {illegal, mem_to_reg, reg_write, mem_write, mem_read, branch,
            alu_src, jump, jalr, lui, auipc, fence} = bundle_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_ctrl_pipe
//  Purpose  : Self-checking bench for decode_ctrl_pipe (CNT_W = 2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_pipe;

    localparam int CNT_W = 2;
`ifdef DECODE_ILLEGAL_EN
    localparam logic [11:0] C_ILL = 12'h800;
`else
    localparam logic [11:0] C_ILL = 12'h000;
`endif

    logic             clk, rst;
    logic             in_valid, in_ready, flush, out_valid, out_ready;
    logic [6:0]       opcode;
    logic             mem_to_reg, reg_write, mem_write, mem_read, branch, alu_src;
    logic             jump, jalr, lui, auipc, fence, illegal;
    logic             mem_req, mem_ack, fence_busy, cnt_err;
    logic [CNT_W-1:0] outstanding;
    logic [11:0]      act_bundle;

    assign act_bundle = {illegal, mem_to_reg, reg_write, mem_write, mem_read, branch,
                         alu_src, jump, jalr, lui, auipc, fence};

    decode_ctrl_pipe #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_write(mem_write),
        .mem_read(mem_read), .branch(branch), .alu_src(alu_src), .jump(jump),
        .jalr(jalr), .lui(lui), .auipc(auipc), .fence(fence), .illegal(illegal),
        .mem_req(mem_req), .mem_ack(mem_ack), .outstanding(outstanding),
        .fence_busy(fence_busy), .cnt_err(cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [11:0] exp;
        string       nm;
    } vec_t;

    vec_t        tbl[12];
    logic [11:0] sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare the presented bundle against the oldest scoreboard entry.
    task automatic chk_out(input string name);
        logic [11:0] e;
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got bundle %0h expected scoreboard entry none", name, act_bundle);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_bundle"}, 32'(act_bundle), 32'(e));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_mem(input logic rq, input logic ak);
        mem_req = rq;
        mem_ack = ak;
        tick();
        mem_req = 1'b0;
        mem_ack = 1'b0;
    endtask

    // Accept a fence while memory is outstanding; expect DRAIN afterwards.
    task automatic accept_fence(input string name);
        opcode   = 7'b0001111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk({name, "_busy"}, 32'(fence_busy), 32'd1);
        chk({name, "_ovalid"}, 32'(out_valid), 32'd0);
        chk({name, "_inready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{7'b0000011, 12'h6A0, "load"};
        tbl[1]  = '{7'b0100011, 12'h120, "store"};
        tbl[2]  = '{7'b0110011, 12'h200, "op"};
        tbl[3]  = '{7'b1101111, 12'h210, "jal"};
        tbl[4]  = '{7'b0110111, 12'h204, "lui"};
        tbl[5]  = '{7'b0010111, 12'h222, "auipc"};
        tbl[6]  = '{7'b1100011, 12'h040, "branch"};
        tbl[7]  = '{7'b0010011, 12'h220, "opimm"};
        tbl[8]  = '{7'b1100111, 12'h238, "jalr"};
        tbl[9]  = '{7'b0001111, 12'h001, "fence0"};
        tbl[10] = '{7'b1111111, C_ILL,   "ill7f"};
        tbl[11] = '{7'b0000001, C_ILL,   "ill01"};

        rst = 1'b1; in_valid = 1'b0; opcode = 7'd0; flush = 1'b0;
        out_ready = 1'b1; mem_req = 1'b0; mem_ack = 1'b0;
        #1;
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_bundle", 32'(act_bundle), 32'd0);
        chk("rst_cnt", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(cnt_err), 32'd0);
        chk("rst_busy", 32'(fence_busy), 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_inready", 32'(in_ready), 32'd1);

        // Back-to-back table, one opcode per cycle, 1-cycle latency.
        for (int i = 0; i < 12; i++) begin
            opcode   = tbl[i].op;
            in_valid = 1'b1;
            sb_q.push_back(tbl[i].exp);
            tick();
            chk_out(tbl[i].nm);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_ovalid", 32'(out_valid), 32'd0);

        // Backpressure: OP-IMM held for 3 cycles, then OP accepted at release.
        opcode = 7'b0010011; in_valid = 1'b1;
        sb_q.push_back(12'h220);
        tick();
        out_ready = 1'b0;
        opcode = 7'b0110011;
        #1;
        chk("bp_inready_lo", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_bundle", 32'(act_bundle), 32'h220);
        end
        chk_out("bp_opimm");
        out_ready = 1'b1;
        #1;
        chk("bp_inready_hi", 32'(in_ready), 32'd1);
        sb_q.push_back(12'h200);
        tick();
        chk_out("bp_op");
        in_valid = 1'b0;
        tick();

        // Fence drain with 3 outstanding operations.
        for (int k = 1; k <= 3; k++) begin
            pulse_mem(1'b1, 1'b0);
            chk("fd_req_cnt", 32'(outstanding), 32'(k));
        end
        sb_q.push_back(12'h001);
        accept_fence("fd");
        pulse_mem(1'b1, 1'b1);
        chk("fd_reqack_cnt", 32'(outstanding), 32'd3);
        chk("fd_reqack_busy", 32'(fence_busy), 32'd1);
        pulse_mem(1'b0, 1'b1);
        pulse_mem(1'b0, 1'b1);
        chk("fd_cnt1", 32'(outstanding), 32'd1);
        chk("fd_still_wait", 32'(out_valid), 32'd0);
        pulse_mem(1'b0, 1'b1);
        chk("fd_cnt0", 32'(outstanding), 32'd0);
        chk("fd_busy_lo", 32'(fence_busy), 32'd0);
        chk_out("fd_fence");
        tick();
        chk("fd_consumed", 32'(out_valid), 32'd0);
        chk("fd_err_clean", 32'(cnt_err), 32'd0);

        // Underflow error.
        pulse_mem(1'b0, 1'b1);
        chk("uf_cnt", 32'(outstanding), 32'd0);
        chk("uf_err", 32'(cnt_err), 32'd1);

        // Overflow error from a clean reset.
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        chk("of_err_reset", 32'(cnt_err), 32'd0);
        for (int k = 0; k < 3; k++) pulse_mem(1'b1, 1'b0);
        chk("of_cnt3", 32'(outstanding), 32'd3);
        chk("of_noerr", 32'(cnt_err), 32'd0);
        pulse_mem(1'b1, 1'b0);
        chk("of_sat", 32'(outstanding), 32'd3);
        chk("of_err", 32'(cnt_err), 32'd1);

        // Flush in DRAIN with count 2.
        pulse_mem(1'b0, 1'b1);
        accept_fence("fl");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fl_busy", 32'(fence_busy), 32'd0);
        chk("fl_ovalid", 32'(out_valid), 32'd0);
        chk("fl_cnt", 32'(outstanding), 32'd2);
        chk("fl_err_kept", 32'(cnt_err), 32'd1);
        chk("fl_inready", 32'(in_ready), 32'd1);

        // Flush beats a same-cycle accept.
        opcode = 7'b0000011; in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("fw_inready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("fw_ovalid", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of DRAIN.
        accept_fence("ar");
        #2 rst = 1'b1;
        #1;
        chk("ar_busy", 32'(fence_busy), 32'd0);
        chk("ar_cnt", 32'(outstanding), 32'd0);
        chk("ar_err", 32'(cnt_err), 32'd0);
        chk("ar_ovalid", 32'(out_valid), 32'd0);
        chk("ar_bundle", 32'(act_bundle), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("ar_inready", 32'(in_ready), 32'd1);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
